// File: rtl/dpm_spadr_pkg.sv
// Shared types and byte-enable constants for the DPM scratchpad access sequencer.
package dpm_spadr_pkg;

    typedef enum logic [1:0] {
        BANK_TMP  = 2'd0,
        BANK_GPR  = 2'd1,
        BANK_IPR  = 2'd2,
        BANK_NONE = 2'd3
    } bank_e;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_WORD = 2'd1,
        LEN_LONG = 2'd2,
        LEN_QUAD = 2'd3
    } len_e;

    typedef enum logic [1:0] {
        ASEL_LIT  = 2'd0,
        ASEL_RN   = 2'd1,
        ASEL_RNP1 = 2'd2,
        ASEL_RNM1 = 2'd3
    } asel_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4
    } state_e;

    localparam logic [3:0] SPW_NONE = 4'b1111;
    localparam logic [3:0] SPW_BYTE = 4'b1110;
    localparam logic [3:0] SPW_WORD = 4'b1100;
    localparam logic [3:0] SPW_LONG = 4'b0000;

    function automatic logic [3:0] len_to_spw(input len_e len);
        case (len)
            LEN_BYTE: len_to_spw = SPW_BYTE;
            LEN_WORD: len_to_spw = SPW_WORD;
            default:  len_to_spw = SPW_LONG;
        endcase
    endfunction

endpackage

// File: rtl/spadr_rnreg.sv
// RN register-number latch: load has priority over inc, inc over dec; all wrap mod 16.
module spadr_rnreg (
    input  logic       i_clk,
    input  logic       i_reset_l,
    input  logic       i_load,
    input  logic [3:0] i_rn_in,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [3:0] o_rn,
    output logic [3:0] o_rn_p1,
    output logic [3:0] o_rn_m1
);

    logic [3:0] r_rn;

    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_rn <= 4'd0;
        end else if (i_load) begin
            r_rn <= i_rn_in;
        end else if (i_inc) begin
            r_rn <= r_rn + 4'd1;
        end else if (i_dec) begin
            r_rn <= r_rn - 4'd1;
        end
    end

    assign o_rn    = r_rn;
    assign o_rn_p1 = r_rn + 4'd1;
    assign o_rn_m1 = r_rn - 4'd1;

endmodule

// File: rtl/spadr_seq.sv
// Scratchpad access sequencer: turns one micro-op into read/write slots on the shared
// scratchpad address, stalling the micro-op stream while extra slots are pending.
module spadr_seq
    import dpm_spadr_pkg::*;
(
    input  logic       clk_h,
    input  logic       reset_l,
    input  logic       uop_valid_h,
    input  logic [1:0] uop_bank_h,
    input  logic [1:0] uop_asel_h,
    input  logic [3:0] uop_lit_h,
    input  logic       uop_wr_h,
    input  logic [1:0] uop_len_h,
    input  logic       rn_load_h,
    input  logic [3:0] rn_in_h,
    input  logic       rn_inc_h,
    input  logic       rn_dec_h,
    output logic       stall_h,
    output logic       wr_slot_h,
    output logic [3:0] rspa_h,
    output logic [3:0] spw_l,
    output logic       rcs_tmp_l,
    output logic       rcs_gpr_l,
    output logic       rcs_ipr_l
);

    state_e     r_state;
    state_e     w_nextState;
    logic [3:0] r_addr;
    bank_e      r_bank;
    len_e       r_len;
    logic       r_wr;
    logic [3:0] r_rspa;
    logic [3:0] r_spw;
    logic [2:0] r_rcs;

    logic [3:0] w_rn;
    logic [3:0] w_rnP1;
    logic [3:0] w_rnM1;
    logic       w_accept;
    logic [3:0] w_uopAddr;
    logic [3:0] w_nextAddr;
    bank_e      w_nextBank;
    len_e       w_nextLen;
    logic [3:0] w_nextRspa;
    logic [3:0] w_nextSpw;
    logic [2:0] w_nextRcs;

    spadr_rnreg u_rnreg (
        .i_clk     (clk_h),
        .i_reset_l (reset_l),
        .i_load    (rn_load_h),
        .i_rn_in   (rn_in_h),
        .i_inc     (rn_inc_h),
        .i_dec     (rn_dec_h),
        .o_rn      (w_rn),
        .o_rn_p1   (w_rnP1),
        .o_rn_m1   (w_rnM1)
    );

    // Address uses RN as it stands before any RN update at the accepting edge.
    always_comb begin
        case (asel_e'(uop_asel_h))
            ASEL_RN:   w_uopAddr = w_rn;
            ASEL_RNP1: w_uopAddr = w_rnP1;
            ASEL_RNM1: w_uopAddr = w_rnM1;
            default:   w_uopAddr = uop_lit_h;
        endcase
    end

    assign w_accept   = uop_valid_h & ~stall_h;
    assign w_nextAddr = w_accept ? w_uopAddr : r_addr;
    assign w_nextBank = w_accept ? bank_e'(uop_bank_h) : r_bank;
    assign w_nextLen  = w_accept ? len_e'(uop_len_h) : r_len;

    always_comb begin
        case (r_state)
            RD0:     stall_h = (r_len == LEN_QUAD) | r_wr;
            RD1:     stall_h = r_wr;
            WR0:     stall_h = (r_len == LEN_QUAD);
            default: stall_h = 1'b0;
        endcase
    end

    assign wr_slot_h = ((r_state == WR0) || (r_state == WR1)) && (r_bank != BANK_NONE);

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Any slot that is the last of its sequence hands over to a newly accepted uop.
    always_comb begin
        w_nextState = w_accept ? RD0 : IDLE;
        case (r_state)
            RD0: begin
                if (r_len == LEN_QUAD) begin
                    w_nextState = RD1;
                end else if (r_wr) begin
                    w_nextState = WR0;
                end
            end
            RD1: begin
                if (r_wr) begin
                    w_nextState = WR0;
                end
            end
            WR0: begin
                if (r_len == LEN_QUAD) begin
                    w_nextState = WR1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_nextRspa = r_rspa;
        w_nextSpw  = SPW_NONE;
        w_nextRcs  = 3'b111;
        if (w_nextState != IDLE) begin
            w_nextRspa = ((w_nextState == RD1) || (w_nextState == WR1)) ? w_nextAddr + 4'd1
                                                                        : w_nextAddr;
            case (w_nextBank)
                BANK_TMP: w_nextRcs = 3'b110;
                BANK_GPR: w_nextRcs = 3'b101;
                BANK_IPR: w_nextRcs = 3'b011;
                default:  w_nextRcs = 3'b111;
            endcase
            if ((w_nextBank != BANK_NONE) && ((w_nextState == WR0) || (w_nextState == WR1))) begin
                w_nextSpw = len_to_spw(w_nextLen);
            end
        end
    end

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            r_addr <= 4'd0;
            r_bank <= BANK_NONE;
            r_len  <= LEN_BYTE;
            r_wr   <= 1'b0;
            r_rspa <= 4'd0;
            r_spw  <= SPW_NONE;
            r_rcs  <= 3'b111;
        end else begin
            r_addr <= w_nextAddr;
            r_bank <= w_nextBank;
            r_len  <= w_nextLen;
            r_wr   <= w_accept ? uop_wr_h : r_wr;
            r_rspa <= w_nextRspa;
            r_spw  <= w_nextSpw;
            r_rcs  <= w_nextRcs;
        end
    end

    assign rspa_h    = r_rspa;
    assign spw_l     = r_spw;
    assign rcs_tmp_l = r_rcs[0];
    assign rcs_gpr_l = r_rcs[1];
    assign rcs_ipr_l = r_rcs[2];

endmodule

// File: tb/tb_spadr_seq.sv
// Randomised bench for spadr_seq against a slot-list reference model of the sequencer.
module tb_spadr_seq;

    logic       clk_h = 1'b0;
    logic       reset_l;
    logic       uop_valid_h;
    logic [1:0] uop_bank_h;
    logic [1:0] uop_asel_h;
    logic [3:0] uop_lit_h;
    logic       uop_wr_h;
    logic [1:0] uop_len_h;
    logic       rn_load_h;
    logic [3:0] rn_in_h;
    logic       rn_inc_h;
    logic       rn_dec_h;
    logic       stall_h;
    logic       wr_slot_h;
    logic [3:0] rspa_h;
    logic [3:0] spw_l;
    logic       rcs_tmp_l;
    logic       rcs_gpr_l;
    logic       rcs_ipr_l;

    spadr_seq dut (
        .clk_h       (clk_h),
        .reset_l     (reset_l),
        .uop_valid_h (uop_valid_h),
        .uop_bank_h  (uop_bank_h),
        .uop_asel_h  (uop_asel_h),
        .uop_lit_h   (uop_lit_h),
        .uop_wr_h    (uop_wr_h),
        .uop_len_h   (uop_len_h),
        .rn_load_h   (rn_load_h),
        .rn_in_h     (rn_in_h),
        .rn_inc_h    (rn_inc_h),
        .rn_dec_h    (rn_dec_h),
        .stall_h     (stall_h),
        .wr_slot_h   (wr_slot_h),
        .rspa_h      (rspa_h),
        .spw_l       (spw_l),
        .rcs_tmp_l   (rcs_tmp_l),
        .rcs_gpr_l   (rcs_gpr_l),
        .rcs_ipr_l   (rcs_ipr_l)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        logic [3:0] rspa;
        logic [2:0] rcs;
        logic [3:0] spw;
        logic       wrSlot;
    } slot_t;

    slot_t      slotQ[$];
    logic [3:0] modelRn;
    logic [3:0] lastRspa;
    int         checkCount = 0;
    int         failCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Each uop expands into its full list of per-cycle slots; one slot is consumed per cycle.
    task automatic buildSlots(input logic [1:0] bank, input logic [3:0] addr, input logic wr,
                              input logic [1:0] len);
        slot_t s;
        int    n;
        logic [2:0] rcs;
        logic [3:0] be;
        n   = (len == 2'd3) ? 2 : 1;
        rcs = (bank == 2'd3) ? 3'b111 : ~(3'b001 << bank);
        case (len)
            2'd0:    be = 4'b1110;
            2'd1:    be = 4'b1100;
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < n; i++) begin
            s.rspa = 4'(addr + i);
            s.rcs = rcs;
            s.spw = 4'hF;
            s.wrSlot = 1'b0;
            slotQ.push_back(s);
        end
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                s.rspa = 4'(addr + i);
                s.rcs = rcs;
                s.spw = (bank == 2'd3) ? 4'hF : be;
                s.wrSlot = (bank != 2'd3);
                slotQ.push_back(s);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] bank, input logic [1:0] asel,
                                 input logic [3:0] lit, input logic wr, input logic [1:0] len,
                                 input logic ld, input logic [3:0] rin, input logic inc,
                                 input logic dec);
        slot_t      cur;
        logic       expStall;
        logic [3:0] addr;
        if (slotQ.size() > 0) begin
            cur = slotQ.pop_front();
            lastRspa = cur.rspa;
        end else begin
            cur.rspa = lastRspa;
            cur.rcs = 3'b111;
            cur.spw = 4'hF;
            cur.wrSlot = 1'b0;
        end
        expStall = (slotQ.size() > 0);
        checkOutput("stall", 32'(stall_h), 32'(expStall));
        checkOutput("rspa", 32'(rspa_h), 32'(cur.rspa));
        checkOutput("rcs", 32'({rcs_ipr_l, rcs_gpr_l, rcs_tmp_l}), 32'(cur.rcs));
        checkOutput("spw", 32'(spw_l), 32'(cur.spw));
        checkOutput("wr_slot", 32'(wr_slot_h), 32'(cur.wrSlot));

        uop_valid_h = v;
        uop_bank_h  = bank;
        uop_asel_h  = asel;
        uop_lit_h   = lit;
        uop_wr_h    = wr;
        uop_len_h   = len;
        rn_load_h   = ld;
        rn_in_h     = rin;
        rn_inc_h    = inc;
        rn_dec_h    = dec;

        case (asel)
            2'd0:    addr = lit;
            2'd1:    addr = modelRn;
            2'd2:    addr = modelRn + 4'd1;
            default: addr = modelRn - 4'd1;
        endcase
        if (v && !expStall) begin
            buildSlots(bank, addr, wr, len);
        end
        if (ld) begin
            modelRn = rin;
        end else if (inc) begin
            modelRn = modelRn + 4'd1;
        end else if (dec) begin
            modelRn = modelRn - 4'd1;
        end
        @(posedge clk_h);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic resetModel();
        slotQ.delete();
        modelRn  = 4'd0;
        lastRspa = 4'd0;
    endtask

    initial begin
        reset_l     = 1'b0;
        uop_valid_h = 1'b0;
        uop_bank_h  = 2'd0;
        uop_asel_h  = 2'd0;
        uop_lit_h   = 4'd0;
        uop_wr_h    = 1'b0;
        uop_len_h   = 2'd0;
        rn_load_h   = 1'b0;
        rn_in_h     = 4'd0;
        rn_inc_h    = 1'b0;
        rn_dec_h    = 1'b0;
        resetModel();
        repeat (2) @(posedge clk_h);
        #1;
        reset_l = 1'b1;

        // GPR long read, then TMP word write.
        applyStimulus(1'b1, 2'd1, 2'd0, 4'd5, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 2'd0, 2'd0, 4'd3, 1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        idleCycles(3);

        // IPR quad write at RN=F wraps to 0 on the second longword.
        applyStimulus(1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 2'd1, 4'd0, 1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        idleCycles(5);

        // Back-to-back reads, then same-cycle RN load sees the old RN.
        applyStimulus(1'b1, 2'd1, 2'd0, 4'd1, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 2'd0, 4'd2, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 2'd0, 4'd3, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 2'd1, 4'd0, 1'b0, 2'd2, 1'b1, 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 2'd1, 4'd0, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        idleCycles(2);

        // NONE bank long write.
        applyStimulus(1'b1, 2'd3, 2'd0, 4'd9, 1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        idleCycles(3);

        // Asynchronous reset in the middle of a WR0 slot.
        applyStimulus(1'b1, 2'd0, 2'd0, 4'd3, 1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("pre_reset_wr_slot", 32'(wr_slot_h), 32'd1);
        #1;
        reset_l = 1'b0;
        #1;
        checkOutput("reset_rcs", 32'({rcs_ipr_l, rcs_gpr_l, rcs_tmp_l}), 32'h7);
        checkOutput("reset_spw", 32'(spw_l), 32'hF);
        checkOutput("reset_rspa", 32'(rspa_h), 32'h0);
        checkOutput("reset_stall", 32'(stall_h), 32'h0);
        checkOutput("reset_wr_slot", 32'(wr_slot_h), 32'h0);
        resetModel();
        @(posedge clk_h);
        #1;
        reset_l = 1'b1;
        idleCycles(3);

        for (int i = 0; i < 500; i++) begin
            logic [2:0] rnOp;
            rnOp = 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 9) < 7), 2'($urandom), 2'($urandom), 4'($urandom),
                          1'($urandom), 2'($urandom), (rnOp == 3'd0), 4'($urandom),
                          (rnOp == 3'd1) || (rnOp == 3'd3), (rnOp == 3'd2) || (rnOp == 3'd3));
        end
        idleCycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
